// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared constants for the PS/2 keyboard receiver: set-2 scan
//             codes, frame/decoder state encodings, held-vector bit indices
//             and a helper mapping an extended code to its arrow-key mask.
//  Revision : 1.0  initial release
// ============================================================================
package ps2_pkg;

    // Set-2 prefix bytes and extended arrow-key make codes
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Bit positions inside held = {up, down, left, right}
    localparam int HELD_UP    = 3;
    localparam int HELD_DOWN  = 2;
    localparam int HELD_LEFT  = 1;
    localparam int HELD_RIGHT = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    typedef enum logic [1:0] {
        D_IDLE   = 2'd0,
        D_EXT    = 2'd1,
        D_BRK    = 2'd2,
        D_EXTBRK = 2'd3
    } dec_state_t;

    // One-hot held-vector mask for an arrow code; zero for any other code
    function automatic logic [3:0] arrow_mask(input logic [7:0] code);
        logic [3:0] m;
        m = 4'b0000;
        case (code)
            SC_UP:    m[HELD_UP]    = 1'b1;
            SC_DOWN:  m[HELD_DOWN]  = 1'b1;
            SC_LEFT:  m[HELD_LEFT]  = 1'b1;
            SC_RIGHT: m[HELD_RIGHT] = 1'b1;
            default:  m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_frame_rx
//  Purpose  : PS/2 line conditioning and 11-bit frame deserialiser.
//             Synchronises both lines, glitch-filters the clock, and on each
//             filtered falling edge steps a start/data/parity/stop FSM with a
//             mid-frame inactivity watchdog.
//  Ports    : clk, reset (sync, active high), ps2_clk, ps2_data (async raw),
//             scan_code (last good byte), scan_valid / frame_err (1-cycle).
//  Revision : 1.0  initial release
// ============================================================================
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int c_CNT_W = $clog2(FILTER_LEN) + 1;
    localparam int c_WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]         r_clk_sync;
    logic [1:0]         r_data_sync;
    logic               r_clk_filt;
    logic [c_CNT_W-1:0] r_filt_cnt;
    logic               r_fall;

    frame_state_t       r_state;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit_cnt;
    logic               r_parity;
    logic [c_WD_W-1:0]  r_wd;

    logic               w_data;
    assign w_data = r_data_sync[1];

    // Synchronisers and clock glitch filter. r_filt_cnt counts consecutive
    // samples that disagree with the filtered level; any agreeing sample
    // restarts the run.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_filt  <= 1'b1;
            r_filt_cnt  <= '0;
            r_fall      <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
            r_fall      <= 1'b0;
            if (r_clk_sync[1] != r_clk_filt) begin
                if (r_filt_cnt == c_CNT_W'(FILTER_LEN - 1)) begin
                    r_clk_filt <= r_clk_sync[1];
                    r_filt_cnt <= '0;
                    r_fall     <= r_clk_filt;   // flipping from 1 to 0
                end else begin
                    r_filt_cnt <= r_filt_cnt + c_CNT_W'(1);
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    // Frame FSM and watchdog. A fall in the same cycle as an expiring
    // watchdog takes priority because it is tested first.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_parity   <= 1'b0;
            r_wd       <= '0;
            scan_code  <= 8'h00;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (r_fall) begin
                r_wd <= '0;
                case (r_state)
                    IDLE: begin
                        if (!w_data) begin
                            r_state   <= DATA;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= PARITY;
                        end
                    end
                    PARITY: begin
                        r_parity <= w_data;
                        r_state  <= STOP;
                    end
                    STOP: begin
                        // Odd parity over data plus parity bit, stop must be 1
                        if (w_data && ((^r_shift) ^ r_parity)) begin
                            scan_code  <= r_shift;
                            scan_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (r_state != IDLE) begin
                if (r_wd == c_WD_W'(TIMEOUT_CYCLES - 1)) begin
                    frame_err <= 1'b1;
                    r_state   <= IDLE;
                    r_wd      <= '0;
                end else begin
                    r_wd <= r_wd + c_WD_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_keyboard_rx
//  Purpose  : Receive-only PS/2 keyboard front end for the game. Decodes
//             set-2 extended make/break sequences of the four arrow keys into
//             one-cycle move pulses and held-key levels.
//  Ports    : clk, reset (sync, active high), ps2_clk, ps2_data (raw),
//             scan_code, scan_valid, frame_err, key_up/down/left/right
//             (1-cycle make pulses), held = {up, down, left, right}.
//  Config   : PS2_TYPEMATIC_FILTER_EN - when defined, auto-repeat makes of a
//             key already held produce no key pulse.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ       = 25_000_000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = CLK_FREQ / 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err,
    output logic       key_up,
    output logic       key_down,
    output logic       key_left,
    output logic       key_right,
    output logic [3:0] held
);

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err)
    );

    dec_state_t r_dec;
    logic [3:0] w_mask;
    logic [3:0] w_press;

    assign w_mask = arrow_mask(scan_code);

`ifdef PS2_TYPEMATIC_FILTER_EN
    // Suppress auto-repeat: only a transition from released to pressed moves
    assign w_press = w_mask & ~held;
`else
    assign w_press = w_mask;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dec     <= D_IDLE;
            held      <= 4'b0000;
            key_up    <= 1'b0;
            key_down  <= 1'b0;
            key_left  <= 1'b0;
            key_right <= 1'b0;
        end else begin
            key_up    <= 1'b0;
            key_down  <= 1'b0;
            key_left  <= 1'b0;
            key_right <= 1'b0;
            if (frame_err) begin
                // A lost byte may have been a prefix; resynchronise
                r_dec <= D_IDLE;
            end else if (scan_valid) begin
                case (r_dec)
                    D_IDLE: begin
                        if (scan_code == SC_EXT) begin
                            r_dec <= D_EXT;
                        end else if (scan_code == SC_BRK) begin
                            r_dec <= D_BRK;
                        end else begin
                            r_dec <= D_IDLE;
                        end
                    end
                    D_EXT: begin
                        if (scan_code == SC_BRK) begin
                            r_dec <= D_EXTBRK;
                        end else begin
                            held      <= held | w_mask;
                            key_up    <= w_press[HELD_UP];
                            key_down  <= w_press[HELD_DOWN];
                            key_left  <= w_press[HELD_LEFT];
                            key_right <= w_press[HELD_RIGHT];
                            r_dec     <= D_IDLE;
                        end
                    end
                    D_BRK: begin
                        r_dec <= D_IDLE;
                    end
                    D_EXTBRK: begin
                        held  <= held & ~w_mask;
                        r_dec <= D_IDLE;
                    end
                    default: r_dec <= D_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_keyboard_rx
//  Purpose  : Directed self-checking bench for ps2_keyboard_rx with
//             FILTER_LEN=4, TIMEOUT_CYCLES=200 and a 20-cycle PS/2 half period.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_keyboard_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;
    logic       key_up, key_down, key_left, key_right;
    logic [3:0] held;

    int total = 0;
    int bad   = 0;

    // Cycle counter and pulse monitors
    int cyc = 0;
    int n_valid = 0, n_err = 0, n_up = 0, n_down = 0, n_left = 0, n_right = 0;
    int n_both = 0;
    int valid_cyc = 0, err_cyc = 0, key_cyc = 0;
    int fall_cyc = 0;

    ps2_keyboard_rx #(
        .CLK_FREQ       (200_000),
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err),
        .key_up     (key_up),
        .key_down   (key_down),
        .key_left   (key_left),
        .key_right  (key_right),
        .held       (held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (scan_valid) begin
            n_valid   <= n_valid + 1;
            valid_cyc <= cyc;
        end
        if (frame_err) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc;
        end
        if (scan_valid && frame_err) n_both <= n_both + 1;
        if (key_up)    n_up    <= n_up + 1;
        if (key_down)  n_down  <= n_down + 1;
        if (key_left)  n_left  <= n_left + 1;
        if (key_right) n_right <= n_right + 1;
        if (key_up || key_down || key_left || key_right) key_cyc <= cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One PS/2 bit: data set mid-high, 20 cycles low, 20 cycles high total
    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (10) @(negedge clk);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        repeat (20) @(negedge clk);
        ps2_clk  = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic ps2_frame(input logic [7:0] d, input logic flip_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ flip_par);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin : main
        int v0, e0, k0, fc, exp_right;

        repeat (5) @(negedge clk);
        // Reset state
        check("rst_scan_code", 32'(scan_code), 32'h00);
        check("rst_held", 32'(held), 32'h0);
        check("rst_pulses", 32'({scan_valid, frame_err, key_up, key_down, key_left, key_right}), 32'h0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Plain byte 0x1C: valid pulse, no key, no error
        v0 = n_valid; e0 = n_err; k0 = n_up + n_down + n_left + n_right;
        ps2_frame(8'h1C, 1'b0);
        check("1c_code", 32'(scan_code), 32'h1C);
        check("1c_valid_cnt", 32'(n_valid - v0), 32'd1);
        check("1c_err_cnt", 32'(n_err - e0), 32'd0);
        check("1c_keys", 32'(n_up + n_down + n_left + n_right - k0), 32'd0);
        check("1c_valid_latency", 32'(valid_cyc - fall_cyc), 32'd7);

        // E0 6B: left make
        k0 = n_left;
        ps2_frame(8'hE0, 1'b0);
        ps2_frame(8'h6B, 1'b0);
        check("left_make_pulse", 32'(n_left - k0), 32'd1);
        check("left_key_latency", 32'(key_cyc - fall_cyc), 32'd8);
        check("left_held", 32'(held), 32'b0010);
        // E0 F0 6B: left break
        ps2_frame(8'hE0, 1'b0);
        ps2_frame(8'hF0, 1'b0);
        ps2_frame(8'h6B, 1'b0);
        check("left_break_held", 32'(held), 32'b0000);
        check("left_break_nopulse", 32'(n_left - k0), 32'd1);

        // 0x75 with bad parity: error, code unchanged; then E0 75 works
        v0 = n_valid; e0 = n_err;
        ps2_frame(8'h75, 1'b1);
        check("par_err_cnt", 32'(n_err - e0), 32'd1);
        check("par_valid_cnt", 32'(n_valid - v0), 32'd0);
        check("par_code_kept", 32'(scan_code), 32'h6B);
        k0 = n_up;
        ps2_frame(8'hE0, 1'b0);
        ps2_frame(8'h75, 1'b0);
        check("up_pulse", 32'(n_up - k0), 32'd1);
        check("up_held", 32'(held), 32'b1000);

        // Stall after start + 5 data bits: watchdog error
        e0 = n_err; v0 = n_valid;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        fc = fall_cyc;
        ps2_data = 1'b1;
        repeat (300) @(negedge clk);
        check("to_err_cnt", 32'(n_err - e0), 32'd1);
        check("to_valid_cnt", 32'(n_valid - v0), 32'd0);
        check("to_err_late_enough", 32'((err_cyc - fc) >= 205), 32'd1);
        check("to_err_early_enough", 32'((err_cyc - fc) <= 208), 32'd1);
        v0 = n_valid; e0 = n_err;
        ps2_frame(8'h29, 1'b0);
        check("to_next_code", 32'(scan_code), 32'h29);
        check("to_next_valid", 32'(n_valid - v0), 32'd1);
        check("to_next_err", 32'(n_err - e0), 32'd0);

        // 2-cycle clock glitches with data low: must not start a frame
        v0 = n_valid; e0 = n_err;
        ps2_data = 1'b0;
        for (int i = 0; i < 3; i++) begin
            repeat (5) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (2) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (10) @(negedge clk);
        ps2_data = 1'b1;
        repeat (250) @(negedge clk);
        check("glitch_no_err", 32'(n_err - e0), 32'd0);
        check("glitch_no_valid", 32'(n_valid - v0), 32'd0);
        ps2_frame(8'h5A, 1'b0);
        check("glitch_next_code", 32'(scan_code), 32'h5A);
        check("glitch_next_valid", 32'(n_valid - v0), 32'd1);
        check("glitch_next_err", 32'(n_err - e0), 32'd0);

        // Reset mid-frame
        e0 = n_err;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_data = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_code", 32'(scan_code), 32'h00);
        check("mid_rst_held", 32'(held), 32'h0);
        check("mid_rst_pulses", 32'({scan_valid, frame_err, key_up, key_down, key_left, key_right}), 32'h0);
        reset = 1'b0;
        repeat (250) @(negedge clk);
        check("mid_rst_no_err", 32'(n_err - e0), 32'd0);
        v0 = n_valid;
        ps2_frame(8'h1C, 1'b0);
        check("mid_rst_next_code", 32'(scan_code), 32'h1C);
        check("mid_rst_next_valid", 32'(n_valid - v0), 32'd1);

        // E0 74 twice without a break
`ifdef PS2_TYPEMATIC_FILTER_EN
        exp_right = 1;
`else
        exp_right = 2;
`endif
        k0 = n_right;
        ps2_frame(8'hE0, 1'b0);
        ps2_frame(8'h74, 1'b0);
        ps2_frame(8'hE0, 1'b0);
        ps2_frame(8'h74, 1'b0);
        check("right_pulses", 32'(n_right - k0), 32'(exp_right));
        check("right_held", 32'(held), 32'b0001);

        check("valid_err_exclusive", 32'(n_both), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #2_000_000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
